logic_gate_unit: RTL and testbench

//  Parametrised, registered successor to the single-bit two-input gate: one N-bit

---
 rtl/logic_gate_unit_if.sv | 26 ++
 rtl/logic_gate_unit.sv | 98 +++++++++
 tb/tb_logic_gate_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/logic_gate_unit_if.sv
// Valid/ready operand and result bundle for logic_gate_unit.
// The upstream/downstream driver uses the master modport; the unit uses the slave modport.
interface logic_gate_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             any;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, zero, any
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, zero, any
    );
endinterface

// File: rtl/logic_gate_unit.sv
// Registered N-bit bitwise gate with run-time function select and a sticky OR accumulator.
// One output register behind a valid/ready handshake; a new beat is taken while the old one drains.
module logic_gate_unit #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input logic              clk,
    input logic              rst_n,
    logic_gate_unit_if.slave bus
);
    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_ACC  = 3'b110,
        OP_CLR  = 3'b111
    } op_t;

    op_t              op_p0;
    logic [WIDTH-1:0] res_p0;
    logic [WIDTH-1:0] acc_nxt_p0;
    logic             rdy_p0;
    logic             take_p0;

    logic [WIDTH-1:0] acc_p1;
    logic [WIDTH-1:0] y_p1;
    logic             vld_p1;
    logic             zero_p1;
    logic             any_p1;

    function automatic logic [WIDTH-1:0] gate_eval(
        input op_t              op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] acc
    );
        case (op)
            OP_AND:  gate_eval = a & b;
            OP_OR:   gate_eval = a | b;
            OP_XOR:  gate_eval = a ^ b;
            OP_NAND: gate_eval = ~(a & b);
            OP_NOR:  gate_eval = ~(a | b);
            OP_XNOR: gate_eval = ~(a ^ b);
            OP_ACC:  gate_eval = acc | a | b;
            default: gate_eval = a | b;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] acc_update(
        input op_t              op,
        input logic [WIDTH-1:0] r,
        input logic [WIDTH-1:0] acc
    );
        case (op)
            OP_ACC:  acc_update = r;
            OP_CLR:  acc_update = ACC_INIT;
            default: acc_update = acc;
        endcase
    endfunction

    // Stage p0: combinational evaluation and handshake; acc_p1 is read directly so
    // back-to-back ACC beats see the value written by the previous accepted beat.
    always_comb begin
        op_p0      = op_t'(bus.op);
        res_p0     = gate_eval(op_p0, bus.a, bus.b, acc_p1);
        acc_nxt_p0 = acc_update(op_p0, res_p0, acc_p1);
        rdy_p0     = !vld_p1 || bus.out_ready;
        take_p0    = bus.in_valid && rdy_p0;
    end

    // Stage p1: output register and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            y_p1    <= '0;
            zero_p1 <= 1'b1;
            any_p1  <= 1'b0;
            acc_p1  <= ACC_INIT;
        end else if (take_p0) begin
            vld_p1  <= 1'b1;
            y_p1    <= res_p0;
            zero_p1 <= ~|res_p0;
            any_p1  <= |res_p0;
            acc_p1  <= acc_nxt_p0;
        end else if (bus.out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.in_ready  = rdy_p0;
    assign bus.out_valid = vld_p1;
    assign bus.y         = y_p1;
    assign bus.zero      = zero_p1;
    assign bus.any       = any_p1;
endmodule

// File: tb/tb_logic_gate_unit.sv
// Randomised and directed bench for logic_gate_unit against a queue-based result model.
`timescale 1ns/1ps
module tb_logic_gate_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_gate_unit_if #(.WIDTH(8)) bus0 ();
    logic_gate_unit_if #(.WIDTH(8)) bus1 ();

    logic_gate_unit #(.WIDTH(8), .ACC_INIT(8'h00)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    logic_gate_unit #(.WIDTH(8), .ACC_INIT(8'h80)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] q[$];
    logic [7:0] acc_m = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_r(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] acc);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return acc | a | b;
            default: return a | b;
        endcase
    endfunction

    // Called 1ns after a rising edge; drives one cycle and checks both sides of the next edge.
    task automatic cycle(input logic iv, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ordy);
        logic rdy_m, drain, take;
        logic [7:0] r;
        bus0.in_valid  = iv;
        bus0.op        = op;
        bus0.a         = a;
        bus0.b         = b;
        bus0.out_ready = ordy;
        #1;
        rdy_m = (q.size() == 0) || ordy;
        drain = (q.size() != 0) && ordy;
        take  = iv && rdy_m;
        chk("in_ready", 32'(bus0.in_ready), 32'(rdy_m));
        if (drain) chk("drain_y", 32'(bus0.y), 32'(q[0]));
        @(posedge clk);
        if (drain) void'(q.pop_front());
        if (take) begin
            r = ref_r(op, a, b, acc_m);
            q.push_back(r);
            if (op == 3'd6) acc_m = r;
            else if (op == 3'd7) acc_m = 8'h00;
        end
        #1;
        chk("out_valid", 32'(bus0.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("y", 32'(bus0.y), 32'(q[0]));
            chk("zero", 32'(bus0.zero), 32'(q[0] == 8'h00));
        end
        chk("zero_any", 32'(bus0.zero), 32'(!bus0.any));
    endtask

    logic [7:0] tt_exp[6];
    logic       r_iv, r_ordy;
    logic [2:0] r_op;
    logic [7:0] r_a, r_b;

    initial begin
        tt_exp = '{8'h48, 8'hDE, 8'h96, 8'hB7, 8'h21, 8'h69};
        rst_n = 1'b0;
        bus0.in_valid = 1'b0; bus0.op = 3'd0; bus0.a = 8'h00; bus0.b = 8'h00; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.op = 3'd6; bus1.a = 8'h00; bus1.b = 8'h00; bus1.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_y", 32'(bus0.y), 32'h00);
        chk("rst_zero", 32'(bus0.zero), 32'd1);
        chk("rst_any", 32'(bus0.any), 32'd0);
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("init80_vld", 32'(bus1.out_valid), 32'd1);
        chk("init80_y", 32'(bus1.y), 32'h80);
        bus1.in_valid = 1'b0;

        // Truth table back-to-back
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 3'(i), 8'hCA, 8'h5C, 1'b1);
            chk("tt_y", 32'(bus0.y), 32'(tt_exp[i]));
            chk("tt_vld", 32'(bus0.out_valid), 32'd1);
        end
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

        // Backpressure
        cycle(1'b1, 3'd0, 8'hFF, 8'h0F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'd1, 8'hAA, 8'h55, 1'b0);
            chk("bp_y", 32'(bus0.y), 32'h0F);
            chk("bp_rdy", 32'(bus0.in_ready), 32'd0);
        end
        cycle(1'b1, 3'd1, 8'h01, 8'h02, 1'b1);
        chk("bp_swap_y", 32'(bus0.y), 32'h03);
        chk("bp_swap_vld", 32'(bus0.out_valid), 32'd1);

        // Accumulate
        cycle(1'b1, 3'd6, 8'h01, 8'h00, 1'b1); chk("acc1", 32'(bus0.y), 32'h01);
        cycle(1'b1, 3'd6, 8'h00, 8'h10, 1'b1); chk("acc2", 32'(bus0.y), 32'h11);
        cycle(1'b1, 3'd6, 8'h80, 8'h00, 1'b1); chk("acc3", 32'(bus0.y), 32'h91);
        cycle(1'b1, 3'd7, 8'h02, 8'h04, 1'b1); chk("clr", 32'(bus0.y), 32'h06);
        cycle(1'b1, 3'd6, 8'h00, 8'h00, 1'b1); chk("acc_after_clr", 32'(bus0.y), 32'h00);
        chk("acc_zero", 32'(bus0.zero), 32'd1);

        // Other ops leave acc alone
        cycle(1'b1, 3'd6, 8'h0F, 8'h00, 1'b1);
        cycle(1'b1, 3'd1, 8'hF0, 8'h00, 1'b1);
        cycle(1'b1, 3'd6, 8'h00, 8'h00, 1'b1); chk("acc_kept", 32'(bus0.y), 32'h0F);

        // Reset mid-burst with a stalled result
        cycle(1'b1, 3'd2, 8'h3C, 8'h0F, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(bus0.out_valid), 32'd0);
        chk("mid_rst_y", 32'(bus0.y), 32'h00);
        chk("mid_rst_zero", 32'(bus0.zero), 32'd1);
        chk("mid_rst_any", 32'(bus0.any), 32'd0);
        chk("mid_rst_rdy", 32'(bus0.in_ready), 32'd1);
        q.delete();
        acc_m = 8'h00;
        bus0.in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 3'd6, 8'h00, 8'h00, 1'b1); chk("acc_reset", 32'(bus0.y), 32'h00);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            r_iv   = 1'($urandom_range(0, 1));
            r_op   = 3'($urandom_range(0, 7));
            r_a    = 8'($urandom);
            r_b    = 8'($urandom);
            r_ordy = ($urandom_range(0, 3) != 0);
            cycle(r_iv, r_op, r_a, r_b, r_ordy);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        chk("final_empty", 32'(bus0.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
